// File: rtl/mpadder_seq.sv
// mpadder_seq: steps mpadder through accumulate, resolve and subtract rounds of one Montgomery product.
// Define MPADDER_SEQ_SUBLIMIT_EN to bound subtract rounds to MAX_SUB and expose sub_err.
module mpadder_seq #(
  parameter int ITERS   = 172,
  parameter int MAX_SUB = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [2:0] m_prime,
  input  logic [7:0] cPrediction,
  input  logic       subtract_finished,
  output logic       c_doubleshift,
  output logic       subtract,
  output logic [3:0] showFluffyPonies,
  output logic [2:0] q_digit,
  output logic       busy,
  output logic       done
`ifdef MPADDER_SEQ_SUBLIMIT_EN
  ,
  output logic       sub_err
`endif
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ACCUM = 3'd1;
  localparam logic [2:0] RES   = 3'd2;
  localparam logic [2:0] SUB   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  logic [2:0] state;
  logic [9:0] iter;
  logic [2:0] step;
  logic       last_round;
  logic       step_end;
  logic       iter_end;
  assign step_end = step == 3'd5;
  assign iter_end = iter == 10'(ITERS - 1);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      iter  <= '0;
      step  <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= start ? ACCUM : IDLE;
          iter  <= '0;
          step  <= '0;
        end
        ACCUM: begin
          iter  <= iter_end ? '0 : iter + 10'd1;
          state <= iter_end ? RES : ACCUM;
        end
        RES: begin
          step  <= step_end ? '0 : step + 3'd1;
          state <= step_end ? SUB : RES;
        end
        SUB: begin
          step  <= step_end ? '0 : step + 3'd1;
          state <= step_end && (subtract_finished || last_round) ? DONE : SUB;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
`ifdef MPADDER_SEQ_SUBLIMIT_EN
  logic [7:0] rnd;
  assign last_round = rnd == 8'(MAX_SUB - 1);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rnd     <= '0;
      sub_err <= 1'b0;
    end else if (state == IDLE && start) begin
      rnd     <= '0;
      sub_err <= 1'b0;
    end else if (state == SUB && step_end) begin
      rnd     <= rnd + 8'd1;
      sub_err <= sub_err | (last_round & ~subtract_finished);
    end
`else
  assign last_round = 1'b0;
`endif
  assign c_doubleshift    = state == ACCUM;
  assign subtract         = state == SUB;
  assign showFluffyPonies = (state == RES || state == SUB) ? {1'b0, step} : 4'b1000;
  assign busy             = state != IDLE;
  assign done             = state == DONE;
  // product taken at operand width then truncated: equals (cPrediction[2:0]*m_prime) mod 8
  assign q_digit          = state == ACCUM ? 3'(cPrediction * m_prime) : 3'd0;
endmodule

// File: tb/tb_mpadder_seq.sv
// tb_mpadder_seq: randomized checks of mpadder_seq against a cycle-schedule model.
module tb_mpadder_seq;
  localparam int I  = 4;
  localparam int MS = 3;
  localparam logic [10:0] IDLE_O = 11'b00_1000_000_00;
  logic       clk = 0, resetn = 0, start = 0, subtract_finished = 0;
  logic [2:0] m_prime = 0;
  logic [7:0] cPrediction = 0;
  logic       c_doubleshift, subtract, busy, done;
  logic [3:0] showFluffyPonies;
  logic [2:0] q_digit;
  logic [10:0] obs;
  int checks = 0, failures = 0;
`ifdef MPADDER_SEQ_SUBLIMIT_EN
  logic sub_err;
`endif
  always #5 clk = ~clk;
  mpadder_seq #(.ITERS(I), .MAX_SUB(MS)) dut (
    .clk(clk), .resetn(resetn), .start(start), .m_prime(m_prime),
    .cPrediction(cPrediction), .subtract_finished(subtract_finished),
    .c_doubleshift(c_doubleshift), .subtract(subtract),
    .showFluffyPonies(showFluffyPonies), .q_digit(q_digit),
    .busy(busy), .done(done)
`ifdef MPADDER_SEQ_SUBLIMIT_EN
    , .sub_err(sub_err)
`endif
  );
  assign obs = {c_doubleshift, subtract, showFluffyPonies, q_digit, busy, done};
  // n = cycle index after the start edge; last = index of the final subtract round
  function automatic logic [10:0] model(int n, int last, logic [2:0] mp, logic [7:0] cp);
    if (n >= 1 && n <= I)
      return {2'b10, 4'd8, 3'((int'(cp[2:0]) * int'(mp)) % 8), 2'b10};
    if (n >= I + 1 && n <= I + 6)
      return {2'b00, 4'(n - I - 1), 3'd0, 2'b10};
    if (n >= I + 7 && n < I + 7 + 6 * (last + 1))
      return {2'b01, 4'((n - I - 7) % 6), 3'd0, 2'b10};
    if (n == I + 7 + 6 * (last + 1))
      return {2'b00, 4'd8, 3'd0, 2'b11};
    return IDLE_O;
  endfunction
  task automatic run_product(input string name, input int k, input int abort_n,
                             input bit rnd_start, input bit hold);
    int last, n_done;
    bit err;
    logic [2:0] mp;
    logic [10:0] e;
    last = k;
    err = 0;
`ifdef MPADDER_SEQ_SUBLIMIT_EN
    if (k >= MS) begin
      last = MS - 1;
      err = 1;
    end
`endif
    n_done = I + 7 + 6 * (last + 1);
    mp = 3'($urandom);
    m_prime = mp;
    start = 1;
    for (int n = 1; n <= n_done; n++) begin
      @(posedge clk);
      #1;
      start = (hold && n == n_done) ? 1'b1 : (rnd_start ? 1'($urandom) : 1'b0);
      cPrediction = 8'($urandom);
      #1;
      e = model(n, last, mp, cPrediction);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL %s n=%0d got=%b exp=%b", name, n, obs, e);
      end
`ifdef MPADDER_SEQ_SUBLIMIT_EN
      checks++;
      if (sub_err !== (err && n == n_done)) begin
        failures++;
        $display("FAIL %s_sub_err n=%0d got=%b exp=%b", name, n, sub_err, err && n == n_done);
      end
`endif
      if (n == abort_n) begin
        #2 resetn = 0;
        #1 checks++;
        if (obs !== IDLE_O) begin
          failures++;
          $display("FAIL %s_abort got=%b exp=%b", name, obs, IDLE_O);
        end
        start = 0;
        @(negedge clk);
        resetn = 1;
        return;
      end
      if (n >= I + 7 && (n - I - 7) % 6 == 5) subtract_finished = ((n - I - 7) / 6) == k;
      else subtract_finished = 1'($urandom);
    end
    @(posedge clk);
    #1;
    if (!hold) start = 0;
    cPrediction = 8'($urandom);
    #1;
    checks++;
    if (obs !== IDLE_O) begin
      failures++;
      $display("FAIL %s_idle got=%b exp=%b", name, obs, IDLE_O);
    end
`ifdef MPADDER_SEQ_SUBLIMIT_EN
    checks++;
    if (sub_err !== err) begin
      failures++;
      $display("FAIL %s_err_hold got=%b exp=%b", name, sub_err, err);
    end
`endif
  endtask
  task automatic test_reset;
    #1;
    checks++;
    if (obs !== IDLE_O) begin
      failures++;
      $display("FAIL reset got=%b exp=%b", obs, IDLE_O);
    end
    @(negedge clk);
    resetn = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (showFluffyPonies !== 4'd8 || busy !== 1'b0) begin
        failures++;
        $display("FAIL idle%0d got=%h/%b exp=8/0", i, showFluffyPonies, busy);
      end
    end
  endtask
  task automatic test_digit;
    m_prime = 3'd3;
    cPrediction = 8'h05;
    #1 checks++;
    if (q_digit !== 3'd0) begin
      failures++;
      $display("FAIL digit_idle got=%0d exp=0", q_digit);
    end
    start = 1;
    @(posedge clk);
    #1 start = 0;
    #1 checks++;
    if (q_digit !== 3'd7) begin
      failures++;
      $display("FAIL digit_05 got=%0d exp=7", q_digit);
    end
    @(posedge clk);
    #1 cPrediction = 8'hFE;
    #1 checks++;
    if (q_digit !== 3'd2) begin
      failures++;
      $display("FAIL digit_fe got=%0d exp=2", q_digit);
    end
    resetn = 0;
    #1 checks++;
    if (obs !== IDLE_O) begin
      failures++;
      $display("FAIL digit_abort got=%b exp=%b", obs, IDLE_O);
    end
    @(negedge clk);
    resetn = 1;
  endtask
  task automatic test_nominal;
    run_product("nominal", 0, -1, 0, 0);
  endtask
  task automatic test_multi_round;
    run_product("multi_round", 2, -1, 0, 0);
  endtask
  task automatic test_start_ignored;
    for (int i = 0; i < 3; i++) run_product("start_ignored", int'($urandom_range(0, 2)), -1, 1, 0);
  endtask
  task automatic test_abort;
    run_product("abort", 1, I + 10, 0, 0);
    run_product("after_abort", 0, -1, 0, 0);
  endtask
  task automatic test_back_to_back;
    run_product("b2b_a", 1, -1, 0, 1);
    run_product("b2b_b", 0, -1, 0, 1);
    run_product("b2b_c", 0, -1, 0, 0);
  endtask
`ifdef MPADDER_SEQ_SUBLIMIT_EN
  task automatic test_limit;
    run_product("limit", MS + 2, -1, 0, 0);
    run_product("limit_clear", 0, -1, 0, 0);
  endtask
`endif
  initial begin
    test_reset;
    test_nominal;
    test_multi_round;
    test_digit;
    test_start_ignored;
    test_abort;
    test_back_to_back;
`ifdef MPADDER_SEQ_SUBLIMIT_EN
    test_limit;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mpadder_seq.md
# mpadder_seq

Step sequencer that drives the `mpadder` carry-save adder through one complete Montgomery product. It issues the accumulate double-shifts, walks the 104-bit resolve chunks, and repeats the chunked subtract rounds until the adder reports completion. During accumulation it also derives the radix-8 reduction digit from `cPrediction`. It sits between the top-level multiplier FSM (start/done) and `mpadder`, which it drives with `c_doubleshift`, `subtract` and `showFluffyPonies`.

## Interface
- `ITERS`, default 172: number of accumulate cycles (3 bits consumed per cycle); legal range 1..1023.
- `MAX_SUB`, default 3: subtract-round limit; only used when `MPADDER_SEQ_SUBLIMIT_EN` is defined.
- `clk`, input, 1: sole clock; all state changes on the rising edge.
- `resetn`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: begin one product; sampled only in IDLE.
- `m_prime`, input, 3: −M⁻¹ mod 8; held stable while `busy`.
- `cPrediction`, input, 8: next-digit carry prediction from `mpadder`.
- `subtract_finished`, input, 1: completion flag from `mpadder`; qualified only in SUB at step 5.
- `c_doubleshift`, output, 1: accumulate/shift enable to `mpadder`.
- `subtract`, output, 1: selects subtract mode in `mpadder`.
- `showFluffyPonies`, output, 4: step code; 0–5 are active chunks, 4'b1000 is hold.
- `q_digit`, output, 3: reduction digit for M-multiple selection.
- `busy`, output, 1: high in any state other than IDLE.
- `done`, output, 1: one-cycle completion pulse.
- `sub_err`, output, 1: subtract-round limit exceeded (present only with the macro).

## Operation
- States and what each does:
  - IDLE: waits for `start`.
  - ACCUM: accumulate; counts `ITERS` cycles.
  - RES: resolve; steps 0..5.
  - SUB: subtract; steps 0..5, repeated per round.
  - DONE: one cycle, then back to IDLE.
- Transitions:
  - IDLE → ACCUM when `start`=1.
  - ACCUM → RES after `ITERS` cycles.
  - RES → SUB after step 5.
  - SUB step 5 → DONE if `subtract_finished`=1; otherwise → SUB step 0 (next round).
  - DONE → IDLE unconditionally.
- Outputs per state:
  - IDLE: `c_doubleshift`=0, `subtract`=0, `showFluffyPonies`=4'b1000.
  - ACCUM: `c_doubleshift`=1, `showFluffyPonies`=4'b1000, `subtract`=0. Iteration counter runs 0..`ITERS`−1; exit when it reaches `ITERS`−1.
  - RES: `c_doubleshift`=0, `subtract`=0, `showFluffyPonies` = 0,1,2,3,4,5 on consecutive cycles.
  - SUB: `subtract`=1, `showFluffyPonies` = 0..5 per round. The round counter increments on each 5 → 0 wrap.
  - DONE: `done`=1, `subtract`=0, `showFluffyPonies`=4'b1000.
- `q_digit` = (`cPrediction`[2:0] × `m_prime`) mod 8. It is combinational in ACCUM and forced to 0 in all other states.
- `start` is ignored while `busy`=1. `start` held high through DONE begins a new product on the cycle after IDLE is re-entered.
- Reset mid-operation: all state goes immediately to IDLE with idle outputs. No partial-product recovery.

## Timing
- Reset values:
  - `c_doubleshift`=0, `subtract`=0, `showFluffyPonies`=4'b1000.
  - `q_digit`=0, `busy`=0, `done`=0, `sub_err`=0.
  - Both counters 0.
- All outputs are decoded from registered state and counters; no input drives an output combinationally except `q_digit`.
- `start` at edge t gives `c_doubleshift`=1 from cycle t+1 through t+`ITERS`.
- RES occupies cycles t+`ITERS`+1 .. t+`ITERS`+6. SUB round k (k starting at 0) begins at t+`ITERS`+7+6k.
- `subtract_finished` sampled at SUB step 5 of round k gives `done` one cycle later.
- Minimum latency from `start` to `done` = `ITERS`+13 cycles.

## Configuration
- `MPADDER_SEQ_SUBLIMIT_EN` defined:
  - If step 5 of round `MAX_SUB`−1 completes without `subtract_finished`, the FSM goes to DONE with `sub_err`=1.
  - `sub_err` stays high until the next `start` or reset.
- Not defined:
  - The `sub_err` port is absent and rounds are unbounded.
  - `MAX_SUB` is unused.

## Test plan
- Reset then idle: `resetn`=0 asynchronously mid-cycle → outputs go to reset values at once. 20 idle cycles → `showFluffyPonies`=8, `busy`=0.
- Nominal product: `ITERS`=4, `start` pulse, `subtract_finished`=1 in round 0 → `c_doubleshift` high 4 cycles, then codes 0..5 with `subtract`=0, then 0..5 with `subtract`=1. `done` 17 cycles after `start`.
- Multi-round subtract: `subtract_finished`=1 only in round 2 → three SUB rounds (18 cycles), `done` at `ITERS`+25.
- Digit derivation: ACCUM with `m_prime`=3, `cPrediction`=8'h05 → `q_digit`=7. `cPrediction`=8'hFE → `q_digit`=2. Outside ACCUM → `q_digit`=0.
- `start` ignored and abort: `start` pulsed during RES → no effect. `resetn` asserted in SUB step 3 → IDLE, and a subsequent `start` runs a full product normally.
- Limit (with macro): `MAX_SUB`=3, `subtract_finished` tied 0 → `done`=1 and `sub_err`=1 after round 2 step 5. The next `start` clears `sub_err`.
